// File: rtl/shift_rs_sched_pkg.sv
// Shared types for the shift reservation station: CDB packet, ALU op codes, RS entry.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package shift_rs_sched_pkg;

  // ROB tag width shared by the CDB packet and RS entries.
  localparam int SRS_ROB_W = 4;

  typedef struct packed {
    logic [31:0]          result;
    logic [SRS_ROB_W-1:0] dest_ROB_entry;
    logic                 branch_result;
    logic                 from_commit;
    logic                 load_step1;
  } CDB_packet_t;

  localparam logic [3:0] ALU_SLL = 4'h1;
  localparam logic [3:0] ALU_SRL = 4'h5;
  localparam logic [3:0] ALU_SRA = 4'hd;

  typedef struct packed {
    logic                 valid;
    logic [SRS_ROB_W-1:0] rob;
    logic [3:0]           aluop;
    logic [31:0]          vj;
    logic [31:0]          vk;
    logic                 qj_pend;
    logic                 qk_pend;
    logic [SRS_ROB_W-1:0] qj;
    logic [SRS_ROB_W-1:0] qk;
  } shift_rs_entry_t;

  // Commit-time and first-half-of-load broadcasts carry no producer result.
  function automatic logic cdb_qualifies(input logic v, input CDB_packet_t p);
    return v & ~p.from_commit & ~p.load_step1;
  endfunction

endpackage

// File: rtl/shift_rs_sched_if.sv
// Dispatch and FU-issue bundle between rename/dispatch, the shift RS and the shift FU.
// Latency: wires only.
// Backpressure: disp_ready throttles dispatch; fu_ready gates fu_valid_in.
// Modports: master = dispatch + FU side, slave = reservation station.
interface shift_rs_sched_if;
  import shift_rs_sched_pkg::*;

  logic                 disp_valid;
  logic                 disp_ready;
  logic [SRS_ROB_W-1:0] disp_rob;
  logic [3:0]           disp_aluop;
  logic [31:0]          disp_vj;
  logic [31:0]          disp_vk;
  logic                 disp_qj_pend;
  logic                 disp_qk_pend;
  logic [SRS_ROB_W-1:0] disp_qj;
  logic [SRS_ROB_W-1:0] disp_qk;

  logic                 fu_ready;
  logic                 fu_valid_in;
  logic [31:0]          fu_A;
  logic [31:0]          fu_B;
  logic [SRS_ROB_W-1:0] fu_rob;
  logic [3:0]           fu_aluop;

  modport master (
    output disp_valid, disp_rob, disp_aluop, disp_vj, disp_vk,
           disp_qj_pend, disp_qk_pend, disp_qj, disp_qk, fu_ready,
    input  disp_ready, fu_valid_in, fu_A, fu_B, fu_rob, fu_aluop
  );

  modport slave (
    input  disp_valid, disp_rob, disp_aluop, disp_vj, disp_vk,
           disp_qj_pend, disp_qk_pend, disp_qj, disp_qk, fu_ready,
    output disp_ready, fu_valid_in, fu_A, fu_B, fu_rob, fu_aluop
  );

endinterface

// File: rtl/shift_rs_sched_age_oldest_pick.sv
// Oldest-requester picker: one-hot grant of the requesting entry no other requester is older than.
// Latency: combinational.
// Backpressure: none; caller masks req.
// Ports: req (N-wide request), age (age[i][j]=1 means entry i is older than j), gnt (one-hot or zero).
module age_oldest_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]        req,
  input  logic [N-1:0][N-1:0] age,
  output logic [N-1:0]        gnt
);

  logic [N-1:0] blocked;

  always_comb begin
    blocked = '0;
    gnt     = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j != i && req[j] && age[j][i]) blocked[i] = 1'b1;
      end
      gnt[i] = req[i] & ~blocked[i];
    end
  end

endmodule

// File: rtl/shift_rs_sched.sv
// Reservation station + oldest-ready issue scheduler for the multi-cycle shift FU.
// Latency: dispatch (operands ready) to fu_valid_in >= 1 cycle; CDB wake-up to issue 1 cycle.
// Backpressure: disp_ready low when all DEPTH entries are valid; issue only while fu_ready.
// Ports: clk, reset (sync, active-high), flush, sif (dispatch + FU bundle, slave side),
//   cdb_valid/cdb (wake-up broadcast), occupancy, byp_valid/byp_yumi/byp_out (zero-shift bypass).
// Optional feature: SHIFT_RS_ZERO_BYPASS_EN routes ready zero-amount shifts to a bypass register.
module shift_rs_sched
  import shift_rs_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ROB_W = SRS_ROB_W  // must equal CDB_packet_t.dest_ROB_entry width
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  shift_rs_sched_if.slave              sif,
  input  logic                         cdb_valid,
  input  CDB_packet_t                  cdb,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         byp_valid,
  input  logic                         byp_yumi,
  output CDB_packet_t                  byp_out
);

  localparam int OCC_W = $clog2(DEPTH+1);

  shift_rs_entry_t             ent [DEPTH];
  logic [DEPTH-1:0][DEPTH-1:0] age;

  logic [DEPTH-1:0] valid_vec;
  logic [DEPTH-1:0] ready_vec;
  logic [DEPTH-1:0] fu_req;
  logic [DEPTH-1:0] fu_gnt;
  logic [DEPTH-1:0] byp_gnt;
  logic [DEPTH-1:0] alloc_oh;
  logic [DEPTH-1:0] free_clr;
  logic             alloc_found;
  logic             disp_fire;
  logic             cdb_hit;
  logic [ROB_W-1:0] cdb_tag;
  shift_rs_entry_t  new_ent;
  logic [OCC_W-1:0] occ_cnt;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic [ROB_W-1:0] sel_rob;
  logic [3:0]       sel_op;
  logic             cdb_unused;

  assign cdb_tag    = cdb.dest_ROB_entry;
  assign cdb_hit    = cdb_qualifies(cdb_valid, cdb);
  assign cdb_unused = cdb.branch_result;

  always_comb begin
    occ_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = ent[i].valid;
      ready_vec[i] = ent[i].valid & ~ent[i].qj_pend & ~ent[i].qk_pend;
      occ_cnt      = occ_cnt + OCC_W'(ent[i].valid);
    end
  end

  assign occupancy = occ_cnt;

  // Lowest-index free slot, from registered valid bits only.
  always_comb begin
    alloc_oh    = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_vec[i] && !alloc_found) begin
        alloc_oh[i] = 1'b1;
        alloc_found = 1'b1;
      end
    end
  end

  assign sif.disp_ready = ~&valid_vec;
  assign disp_fire      = sif.disp_valid & sif.disp_ready;

  // Incoming entry, picking up a same-cycle CDB result for a pending operand.
  always_comb begin
    new_ent         = '0;
    new_ent.valid   = 1'b1;
    new_ent.rob     = sif.disp_rob;
    new_ent.aluop   = sif.disp_aluop;
    new_ent.vj      = sif.disp_vj;
    new_ent.vk      = sif.disp_vk;
    new_ent.qj      = sif.disp_qj;
    new_ent.qk      = sif.disp_qk;
    new_ent.qj_pend = sif.disp_qj_pend;
    new_ent.qk_pend = sif.disp_qk_pend;
    if (sif.disp_qj_pend && cdb_hit && sif.disp_qj == cdb_tag) begin
      new_ent.vj      = cdb.result;
      new_ent.qj_pend = 1'b0;
    end
    if (sif.disp_qk_pend && cdb_hit && sif.disp_qk == cdb_tag) begin
      new_ent.vk      = cdb.result;
      new_ent.qk_pend = 1'b0;
    end
  end

`ifdef SHIFT_RS_ZERO_BYPASS_EN
  logic [DEPTH-1:0] zero_vec;
  logic [DEPTH-1:0] byp_req;
  CDB_packet_t      byp_pkt;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) zero_vec[i] = (ent[i].vk[4:0] == 5'd0);
  end

  // Zero-amount shifts never reach the FU; they wait for the bypass register.
  assign fu_req  = ready_vec & ~zero_vec;
  assign byp_req = byp_valid ? '0 : (ready_vec & zero_vec);

  age_oldest_pick #(.N(DEPTH)) u_byp_pick (
    .req (byp_req),
    .age (age),
    .gnt (byp_gnt)
  );

  always_comb begin
    byp_pkt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (byp_gnt[i]) begin
        byp_pkt.result         = ent[i].vj;
        byp_pkt.dest_ROB_entry = ent[i].rob;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      byp_valid <= 1'b0;
      byp_out   <= '0;
    end else if (byp_valid) begin
      if (byp_yumi) begin
        byp_valid <= 1'b0;
        byp_out   <= '0;
      end
    end else if (|byp_gnt) begin
      byp_valid <= 1'b1;
      byp_out   <= byp_pkt;
    end
  end
`else
  logic byp_unused;

  assign fu_req     = ready_vec;
  assign byp_gnt    = '0;
  assign byp_valid  = 1'b0;
  assign byp_out    = '0;
  assign byp_unused = byp_yumi;
`endif

  age_oldest_pick #(.N(DEPTH)) u_fu_pick (
    .req (fu_req),
    .age (age),
    .gnt (fu_gnt)
  );

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_rob = '0;
    sel_op  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fu_gnt[i]) begin
        sel_a   = ent[i].vj;
        sel_b   = ent[i].vk;
        sel_rob = ent[i].rob;
        sel_op  = ent[i].aluop;
      end
    end
  end

  // Gating on fu_ready keeps the data bus at zero whenever nothing issues.
  assign sif.fu_valid_in = sif.fu_ready & |fu_req;
  assign sif.fu_A        = sif.fu_ready ? sel_a   : '0;
  assign sif.fu_B        = sif.fu_ready ? sel_b   : '0;
  assign sif.fu_rob      = sif.fu_ready ? sel_rob : '0;
  assign sif.fu_aluop    = sif.fu_ready ? sel_op  : '0;

  assign free_clr = (fu_gnt & {DEPTH{sif.fu_ready}}) | byp_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      age <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (free_clr[i]) begin
          ent[i].valid <= 1'b0;
        end else if (ent[i].valid && cdb_hit) begin
          if (ent[i].qj_pend && ent[i].qj == cdb_tag) begin
            ent[i].vj      <= cdb.result;
            ent[i].qj_pend <= 1'b0;
          end
          if (ent[i].qk_pend && ent[i].qk == cdb_tag) begin
            ent[i].vk      <= cdb.result;
            ent[i].qk_pend <= 1'b0;
          end
        end
        // The allocated slot is invalid, so it never collides with issue or wake-up.
        if (disp_fire && alloc_oh[i]) ent[i] <= new_ent;
      end
      // New entry becomes younger than everyone: clear its row, set its column.
      if (disp_fire) begin
        for (int i = 0; i < DEPTH; i++) begin
          for (int j = 0; j < DEPTH; j++) begin
            if (alloc_oh[i])      age[i][j] <= 1'b0;
            else if (alloc_oh[j]) age[i][j] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_rs_sched.sv
// Self-checking bench for shift_rs_sched: directed scenarios plus randomized traffic
// compared every cycle against an in-order queue model of the reservation station.
// Covers SHIFT_RS_ZERO_BYPASS_EN when that macro is defined.
module tb_shift_rs_sched;
  import shift_rs_sched_pkg::*;

  localparam int DEPTH = 4;
`ifdef SHIFT_RS_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        cdb_valid;
  CDB_packet_t cdb;
  logic [2:0]  occupancy;
  logic        byp_valid;
  logic        byp_yumi;
  CDB_packet_t byp_out;

  shift_rs_sched_if sif();

  shift_rs_sched #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .sif       (sif),
    .cdb_valid (cdb_valid),
    .cdb       (cdb),
    .occupancy (occupancy),
    .byp_valid (byp_valid),
    .byp_yumi  (byp_yumi),
    .byp_out   (byp_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: entries kept in dispatch order, oldest at index 0.
  typedef struct {
    logic [3:0]  rob;
    logic [3:0]  op;
    logic [31:0] vj;
    logic [31:0] vk;
    bit          pj;
    bit          pk;
    logic [3:0]  qj;
    logic [3:0]  qk;
  } m_ent_t;

  m_ent_t mq[$];
`ifdef SHIFT_RS_ZERO_BYPASS_EN
  bit          mbv = 1'b0;
  logic [31:0] mb_res = '0;
  logic [3:0]  mb_rob = '0;
`endif

  function automatic bit m_ready(input m_ent_t e);
    return !e.pj && !e.pk;
  endfunction

  task automatic model_cycle();
    int     osz, fi, bi;
    bit     efv, cq;
    m_ent_t e;
    logic [31:0] ea, eb;
    logic [3:0]  er, eo;
    osz = mq.size();
    fi = -1;
    bi = -1;
    for (int k = 0; k < mq.size(); k++)
      if (fi < 0 && m_ready(mq[k]) && (!BYP || mq[k].vk[4:0] != 5'd0)) fi = k;
    efv = sif.fu_ready && (fi >= 0);
    ea = '0; eb = '0; er = '0; eo = '0;
    if (efv) begin
      ea = mq[fi].vj; eb = mq[fi].vk; er = mq[fi].rob; eo = mq[fi].op;
    end
    chk("disp_ready", 32'(sif.disp_ready), 32'(osz < DEPTH));
    chk("occupancy", 32'(occupancy), 32'(osz));
    chk("fu_valid_in", 32'(sif.fu_valid_in), 32'(efv));
    chk("fu_A", sif.fu_A, ea);
    chk("fu_B", sif.fu_B, eb);
    chk("fu_rob", 32'(sif.fu_rob), 32'(er));
    chk("fu_aluop", 32'(sif.fu_aluop), 32'(eo));
`ifdef SHIFT_RS_ZERO_BYPASS_EN
    chk("byp_valid", 32'(byp_valid), 32'(mbv));
    if (mbv) begin
      chk("byp_result", byp_out.result, mb_res);
      chk("byp_ctl", 32'({byp_out.dest_ROB_entry, byp_out.branch_result,
                          byp_out.from_commit, byp_out.load_step1}), 32'({mb_rob, 3'b000}));
    end
`else
    chk("byp_valid_off", 32'(byp_valid), 32'd0);
    chk("byp_out_off", byp_out.result | 32'({byp_out.dest_ROB_entry, byp_out.branch_result,
                          byp_out.from_commit, byp_out.load_step1}), 32'd0);
`endif

    if (reset || flush) begin
      mq.delete();
`ifdef SHIFT_RS_ZERO_BYPASS_EN
      mbv = 1'b0;
`endif
    end else begin
`ifdef SHIFT_RS_ZERO_BYPASS_EN
      if (!mbv)
        for (int k = 0; k < mq.size(); k++)
          if (bi < 0 && m_ready(mq[k]) && mq[k].vk[4:0] == 5'd0) bi = k;
      if (mbv && byp_yumi) mbv = 1'b0;
      else if (bi >= 0) begin
        mbv = 1'b1; mb_res = mq[bi].vj; mb_rob = mq[bi].rob;
      end
`endif
      if (efv && bi >= 0) begin
        if (fi > bi) begin mq.delete(fi); mq.delete(bi); end
        else begin mq.delete(bi); mq.delete(fi); end
      end else if (efv) mq.delete(fi);
      else if (bi >= 0) mq.delete(bi);

      cq = cdb_valid && !cdb.from_commit && !cdb.load_step1;
      if (cq) begin
        for (int k = 0; k < mq.size(); k++) begin
          if (mq[k].pj && mq[k].qj == cdb.dest_ROB_entry) begin mq[k].vj = cdb.result; mq[k].pj = 0; end
          if (mq[k].pk && mq[k].qk == cdb.dest_ROB_entry) begin mq[k].vk = cdb.result; mq[k].pk = 0; end
        end
      end
      if (sif.disp_valid && osz < DEPTH) begin
        e.rob = sif.disp_rob; e.op = sif.disp_aluop;
        e.vj = sif.disp_vj; e.vk = sif.disp_vk;
        e.pj = sif.disp_qj_pend; e.pk = sif.disp_qk_pend;
        e.qj = sif.disp_qj; e.qk = sif.disp_qk;
        if (e.pj && cq && e.qj == cdb.dest_ROB_entry) begin e.vj = cdb.result; e.pj = 0; end
        if (e.pk && cq && e.qk == cdb.dest_ROB_entry) begin e.vk = cdb.result; e.pk = 0; end
        mq.push_back(e);
      end
    end
  endtask

  // Compare process: inputs settle at the falling edge, outputs are checked 2 time units later.
  always begin
    @(negedge clk);
    #2;
    if (chk_en) model_cycle();
  end

  task automatic idle();
    sif.disp_valid = 1'b0;
    sif.disp_qj_pend = 1'b0;
    sif.disp_qk_pend = 1'b0;
    cdb_valid = 1'b0;
    cdb = '0;
    flush = 1'b0;
    byp_yumi = 1'b0;
  endtask

  task automatic disp(input logic [3:0] rob, input logic [3:0] op, input logic [31:0] vj,
                      input logic [31:0] vk, input bit pj, input logic [3:0] qj,
                      input bit pk, input logic [3:0] qk);
    sif.disp_valid = 1'b1;
    sif.disp_rob = rob;     sif.disp_aluop = op;
    sif.disp_vj = vj;       sif.disp_vk = vk;
    sif.disp_qj_pend = pj;  sif.disp_qj = qj;
    sif.disp_qk_pend = pk;  sif.disp_qk = qk;
  endtask

  task automatic cdb_send(input logic [3:0] tag, input logic [31:0] res, input bit fc);
    cdb_valid = 1'b1;
    cdb = '0;
    cdb.dest_ROB_entry = tag;
    cdb.result = res;
    cdb.from_commit = fc;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    sif.fu_ready = 1'b0;
    sif.disp_rob = '0; sif.disp_aluop = '0; sif.disp_vj = '0; sif.disp_vk = '0;
    sif.disp_qj = '0; sif.disp_qk = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("rst_disp_ready", 32'(sif.disp_ready), 32'd1);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_fu_valid", 32'(sif.fu_valid_in), 32'd0);
    chk("rst_byp_valid", 32'(byp_valid), 32'd0);

    // SLL 1 by 4 issues one cycle after dispatch.
    @(negedge clk);
    sif.fu_ready = 1'b1;
    disp(4'd1, ALU_SLL, 32'h1, 32'd4, 0, 4'd0, 0, 4'd0);
    @(negedge clk); idle(); #1;
    chk("sll_valid", 32'(sif.fu_valid_in), 32'd1);
    chk("sll_A", sif.fu_A, 32'h1);
    chk("sll_B", sif.fu_B, 32'd4);
    chk("sll_op", 32'(sif.fu_aluop), 32'(ALU_SLL));
    @(negedge clk); #1;
    chk("sll_occ_after", 32'(occupancy), 32'd0);

    // SRA waiting on tag 5; CDB two cycles later, issue the cycle after.
    @(negedge clk);
    disp(4'd2, ALU_SRA, 32'h8000_0000, 32'd0, 0, 4'd0, 1, 4'd5);
    @(negedge clk); idle(); #1;
    chk("sra_wait", 32'(sif.fu_valid_in), 32'd0);
    @(negedge clk); cdb_send(4'd5, 32'd3, 0); #1;
    chk("sra_no_same_cycle", 32'(sif.fu_valid_in), 32'd0);
    @(negedge clk); idle(); #1;
    chk("sra_issue", 32'(sif.fu_valid_in), 32'd1);
    chk("sra_B", sif.fu_B, 32'd3);
    chk("sra_rob", 32'(sif.fu_rob), 32'd2);

    // Fill, drop a fifth dispatch, drain in dispatch order.
    @(negedge clk);
    sif.fu_ready = 1'b0;
    for (int r = 1; r <= 4; r++) begin
      disp(4'(r), ALU_SRL, 32'(r * 16), 32'(r), 0, 4'd0, 0, 4'd0);
      @(negedge clk);
    end
    disp(4'd9, ALU_SRL, 32'h99, 32'd1, 0, 4'd0, 0, 4'd0); #1;
    chk("full_disp_ready", 32'(sif.disp_ready), 32'd0);
    chk("full_occ", 32'(occupancy), 32'd4);
    @(negedge clk); idle(); #1;
    chk("full_drop_occ", 32'(occupancy), 32'd4);
    @(negedge clk);
    sif.fu_ready = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      #1;
      chk("drain_valid", 32'(sif.fu_valid_in), 32'd1);
      chk("drain_order", 32'(sif.fu_rob), 32'(r));
      @(negedge clk);
    end
    #1;
    chk("drain_empty", 32'(sif.fu_valid_in), 32'd0);

    // Commit-side broadcast must not wake; a producer broadcast wakes j and k of two entries.
    @(negedge clk);
    sif.fu_ready = 1'b0;
    disp(4'd3, ALU_SLL, 32'd0, 32'd0, 1, 4'd7, 1, 4'd7);
    @(negedge clk);
    disp(4'd4, ALU_SRA, 32'd0, 32'd0, 1, 4'd7, 1, 4'd7);
    @(negedge clk); idle(); cdb_send(4'd7, 32'h55, 1);
    @(negedge clk); cdb_send(4'd7, 32'd2, 0); sif.fu_ready = 1'b1; #1;
    chk("commit_no_wake", 32'(sif.fu_valid_in), 32'd0);
    @(negedge clk); idle(); #1;
    chk("wake_issue", 32'(sif.fu_valid_in), 32'd1);
    chk("wake_rob", 32'(sif.fu_rob), 32'd3);
    chk("wake_A", sif.fu_A, 32'd2);
    chk("wake_B", sif.fu_B, 32'd2);
    @(negedge clk); #1;
    chk("wake_second", 32'(sif.fu_rob), 32'd4);

    // Flush beats a simultaneous dispatch.
    @(negedge clk);
    sif.fu_ready = 1'b0;
    for (int r = 10; r <= 12; r++) begin
      disp(4'(r), ALU_SLL, 32'(r), 32'd1, 0, 4'd0, 0, 4'd0);
      @(negedge clk);
    end
    disp(4'd13, ALU_SLL, 32'd13, 32'd1, 0, 4'd0, 0, 4'd0);
    flush = 1'b1;
    @(negedge clk); idle(); sif.fu_ready = 1'b1; #1;
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_no_issue", 32'(sif.fu_valid_in), 32'd0);

    // Zero-amount shift (vk=32).
    @(negedge clk);
    disp(4'd6, ALU_SRL, 32'hF0, 32'd32, 0, 4'd0, 0, 4'd0);
    @(negedge clk); idle(); #1;
`ifdef SHIFT_RS_ZERO_BYPASS_EN
    chk("byp_no_fu", 32'(sif.fu_valid_in), 32'd0);
    @(negedge clk); #1;
    chk("byp_set", 32'(byp_valid), 32'd1);
    chk("byp_res", byp_out.result, 32'hF0);
    chk("byp_rob", 32'(byp_out.dest_ROB_entry), 32'd6);
    chk("byp_no_fu2", 32'(sif.fu_valid_in), 32'd0);
    @(negedge clk); #1;
    chk("byp_hold", 32'(byp_valid), 32'd1);
    byp_yumi = 1'b1;
    @(negedge clk); byp_yumi = 1'b0; #1;
    chk("byp_clear", 32'(byp_valid), 32'd0);
    chk("byp_occ", 32'(occupancy), 32'd0);
`else
    chk("zero_to_fu", 32'(sif.fu_valid_in), 32'd1);
    chk("zero_B", sif.fu_B, 32'd32);
    chk("zero_byp_off", 32'(byp_valid), 32'd0);
`endif

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 49) == 0);
      sif.disp_valid = $urandom_range(0, 1) != 0;
      sif.disp_rob = 4'($urandom);
      case ($urandom_range(0, 2))
        0:       sif.disp_aluop = ALU_SLL;
        1:       sif.disp_aluop = ALU_SRL;
        default: sif.disp_aluop = ALU_SRA;
      endcase
      sif.disp_vj = $urandom;
      case ($urandom_range(0, 3))
        0:       sif.disp_vk = 32'd0;
        1:       sif.disp_vk = 32'd32;
        2:       sif.disp_vk = 32'($urandom_range(0, 31));
        default: sif.disp_vk = $urandom;
      endcase
      sif.disp_qj_pend = $urandom_range(0, 4) < 2;
      sif.disp_qk_pend = $urandom_range(0, 4) < 2;
      sif.disp_qj = 4'($urandom_range(0, 7));
      sif.disp_qk = 4'($urandom_range(0, 7));
      cdb_valid = $urandom_range(0, 1) != 0;
      cdb.result = $urandom;
      cdb.dest_ROB_entry = 4'($urandom_range(0, 7));
      cdb.branch_result = $urandom_range(0, 1) != 0;
      cdb.from_commit = $urandom_range(0, 5) == 0;
      cdb.load_step1 = $urandom_range(0, 5) == 0;
      sif.fu_ready = $urandom_range(0, 2) != 0;
      byp_yumi = $urandom_range(0, 1) != 0;
    end

    @(negedge clk);
    reset = 1'b0;
    idle();
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
